// File: rtl/lab_007_alarm_panel.sv
// Keypad alarm panel: code entry, timed exit/entry/siren arming FSM.
// Optional keypad lockout after repeated bad codes: define ALARM_PANEL_LOCKOUT_EN.
module lab_007_alarm_panel #(
   parameter logic [15:0] CODE           = 16'h1234,
   parameter int unsigned EXIT_CYCLES    = 8,
   parameter int unsigned ENTRY_CYCLES   = 8,
   parameter int unsigned SIREN_CYCLES   = 16,
   parameter int unsigned LOCKOUT_CYCLES = 32
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_digit,
   input  logic       key_enter,
   input  logic       key_clear,
   input  logic       key_arm_away,
   input  logic       key_arm_stay,
   input  logic       secure,
   input  logic       alarm,
   output logic       alarm_set,
   output logic       alarm_stay,
   output logic       siren,
   output logic       code_ok,
   output logic       code_bad,
   output logic       locked,
   output logic [2:0] state
);

   typedef enum logic [2:0] {
      DISARMED = 3'd0,
      EXIT     = 3'd1,
      ARMED    = 3'd2,
      ENTRY    = 3'd3,
      ALARM    = 3'd4
   } state_t;

   // Timers count down from length-1 so each timed state lasts exactly its length.
   localparam logic [15:0] EXIT_LOAD  = 16'(EXIT_CYCLES - 1);
   localparam logic [15:0] ENTRY_LOAD = 16'(ENTRY_CYCLES - 1);
   localparam logic [15:0] SIREN_LOAD = 16'(SIREN_CYCLES - 1);

   state_t      st;
   logic [15:0] timer;
   logic [15:0] buffer;
   logic [2:0]  count;
   logic        keys_on;
   logic        do_clear, do_enter, do_digit, do_away, do_stay, match;
   logic        unused_secure;

   assign state         = st;
   assign unused_secure = secure;

`ifdef ALARM_PANEL_LOCKOUT_EN
   localparam logic [15:0] LOCK_LOAD = 16'(LOCKOUT_CYCLES - 1);
   logic [15:0] lock_timer;
   logic [1:0]  bad_cnt;
   assign keys_on = !locked;
`else
   assign keys_on = 1'b1;
   assign locked  = 1'b0;
`endif

   // Key priority: clear > enter > digit > arm_away > arm_stay.
   always_comb begin
      do_clear = keys_on & key_clear;
      do_enter = keys_on & !key_clear & key_enter;
      do_digit = keys_on & !key_clear & !key_enter & key_valid;
      do_away  = keys_on & !key_clear & !key_enter & !key_valid & key_arm_away;
      do_stay  = keys_on & !key_clear & !key_enter & !key_valid & !key_arm_away & key_arm_stay;
      match    = (count == 3'd4) && (buffer == CODE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st         <= DISARMED;
         timer      <= 16'd0;
         buffer     <= 16'd0;
         count      <= 3'd0;
         alarm_set  <= 1'b0;
         alarm_stay <= 1'b0;
         siren      <= 1'b0;
         code_ok    <= 1'b0;
         code_bad   <= 1'b0;
`ifdef ALARM_PANEL_LOCKOUT_EN
         locked     <= 1'b0;
         lock_timer <= 16'd0;
         bad_cnt    <= 2'd0;
`endif
      end else begin
         code_ok  <= 1'b0;
         code_bad <= 1'b0;
         if (do_clear) begin
            buffer <= 16'd0;
            count  <= 3'd0;
         end else if (do_enter) begin
            buffer   <= 16'd0;
            count    <= 3'd0;
            code_ok  <= match;
            code_bad <= !match;
         end else if (do_digit && (key_digit <= 4'd9)) begin
            buffer <= {buffer[11:0], key_digit};
            if (count != 3'd4) begin
               count <= count + 3'd1;
            end
         end

         // A good code disarms ahead of any timer expiry or alarm transition.
         if (do_enter && match && (st != DISARMED)) begin
            st         <= DISARMED;
            timer      <= 16'd0;
            alarm_set  <= 1'b0;
            alarm_stay <= 1'b0;
            siren      <= 1'b0;
         end else begin
            case (st)
               DISARMED: begin
                  if (do_away || do_stay) begin
                     st         <= EXIT;
                     timer      <= EXIT_LOAD;
                     alarm_stay <= do_stay;
                  end
               end
               EXIT: begin
                  if (timer == 16'd0) begin
                     st        <= ARMED;
                     alarm_set <= 1'b1;
                  end else begin
                     timer <= timer - 16'd1;
                  end
               end
               ARMED: begin
                  if (alarm) begin
                     st    <= ENTRY;
                     timer <= ENTRY_LOAD;
                  end
               end
               ENTRY: begin
                  if (timer == 16'd0) begin
                     st    <= ALARM;
                     timer <= SIREN_LOAD;
                     siren <= 1'b1;
                  end else begin
                     timer <= timer - 16'd1;
                  end
               end
               ALARM: begin
                  if (timer == 16'd0) begin
                     st    <= ARMED;
                     siren <= 1'b0;
                  end else begin
                     timer <= timer - 16'd1;
                  end
               end
               default: begin
                  st         <= DISARMED;
                  timer      <= 16'd0;
                  alarm_set  <= 1'b0;
                  alarm_stay <= 1'b0;
                  siren      <= 1'b0;
               end
            endcase
         end

`ifdef ALARM_PANEL_LOCKOUT_EN
         if (locked) begin
            if (lock_timer == 16'd0) begin
               locked <= 1'b0;
            end else begin
               lock_timer <= lock_timer - 16'd1;
            end
         end else if (do_enter) begin
            if (match) begin
               bad_cnt <= 2'd0;
            end else if (bad_cnt == 2'd2) begin
               bad_cnt    <= 2'd0;
               locked     <= 1'b1;
               lock_timer <= LOCK_LOAD;
            end else begin
               bad_cnt <= bad_cnt + 2'd1;
            end
         end
`endif
      end
   end

endmodule
